psum_acc: RTL and testbench
===========================

Name: psum_acc

Overview:
- Sits directly downstream of the systolic MAC array; consumes its per-column partial sums (COLUMN lanes of OW bits) over a first/last-framed valid/ready stream.
- Accumulates partial sums across input-channel chunks per output pixel, adds per-column bias, requantizes (round, shift, saturate, optional ReLU) to QW-bit activations.
- Emits one COLUMN-wide activation word per completed group toward the output buffer.

Parameters:
- COLUMN, 6, number of output-channel lanes (MAC array columns)
- OW, 21, signed partial-sum width per lane from the MAC array
- AW, 32, signed accumulator and bias width per lane
- QW, 8, signed output activation width per lane
- SW, 5, shift-amount width (shift range 0..AW-1)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- acc_m_data  in  COLUMN*OW  signed partial sums, lane k at [k*OW +: OW]
- acc_m_first  in  1  first beat of a group
- acc_m_last  in  1  last beat of a group (first and last may both be 1)
- acc_m_valid  in  1  input beat valid
- acc_m_ready  out  1  input beat accepted when valid&ready
- bias  in  COLUMN*AW  signed per-lane bias, sampled on first beat
- shift  in  SW  right-shift amount, sampled on first beat
- relu_en  in  1  clamp negatives to 0, sampled on first beat
- acc_s_data  out  COLUMN*QW  signed activations, lane k at [k*QW +: QW]
- acc_s_valid  out  1  output word valid
- acc_s_ready  in  1  downstream accepts
- acc_err  out  1  sticky framing-error flag

Behaviour:
- Reset (rst=1 at clock edge): acc_s_valid=0, acc_s_data=0, acc_err=0, acc_m_ready=1, accumulators=0, group_open=0, done=0. Reset mid-group discards the partial group and any pending output.
- Stage 1 (accumulate), on accepted beat: first=1 -> acc[k]=bias[k]+sext(data[k]), latch shift/relu_en; first=0 -> acc[k]+=sext(data[k]). Arithmetic wraps modulo 2^AW.
- group_open set on accepted beat with last=0, cleared on accepted beat with last=1.
- done set on accepted last beat; cleared when Stage 2 loads.
- Stage 2 (requant/output register) loads when done && (!acc_s_valid || acc_s_ready); sets acc_s_valid=1. acc_s_valid clears on acc_s_ready with no new load.
- Requant per lane: shift=0 -> r=acc; else r=(acc + 2^(shift-1)) >>> shift (round half toward +inf). Saturate r to [-2^(QW-1), 2^(QW-1)-1]; if relu_en, negative -> 0.
- acc_m_ready = !done || Stage 2 loads this cycle. Loading Stage 2 and accepting a new beat in the same cycle is legal (Stage 2 uses the old accumulator value).
- Latency: last beat accepted at cycle t -> acc_s_valid=1 at t+2. Throughput: one single-beat group per cycle with acc_s_ready held high.
- acc_s_data/acc_s_valid are held stable while acc_s_valid && !acc_s_ready.
- Framing errors (set acc_err, which stays set until rst):
  - first=0 beat with group_open=0: treated as first (bias added, config latched).
  - first=1 beat with group_open=1: partial group discarded, restarted.
- bias/shift/relu_en changes mid-group have no effect until the next first beat.

Decomposition:
- Shared package/header: default COLUMN/OW/AW/QW/SW, QMAX/QMIN constants, sign-extend and saturate functions.
- One sub-module: psum_requant (combinational single-lane round/shift/saturate/ReLU, parameters AW, QW, SW), instantiated COLUMN times.

Test Plan:
- Reset: rst=1 two cycles -> acc_s_valid=0, acc_s_data=0, acc_m_ready=1, acc_err=0.
- Single-beat group, bias=10, data=20, shift=0, relu_en=0, first=last=1 -> lane=30, acc_s_valid 2 cycles after accept.
- Three-beat group, data 100, 200, -50, bias 0, shift 2 -> (250+2)>>>2 = 63. Also acc -5, shift 1 -> -2.
- Saturation: sum 1000, shift 0 -> 127; sum -1000 -> -128; sum -1000 with relu_en=1 -> 0.
- Backpressure: acc_s_ready=0 with output full and a second group done -> acc_m_ready=0 and acc_s_data stable. Raise acc_s_ready -> both results delivered in order, none lost or duplicated.
- Framing: first=0 beat after reset -> acc_err=1, result = bias+data. Then first=1 mid-group -> restart, prior partial discarded. rst mid-group -> acc_err=0, no output emitted.

Source files
------------

// File: rtl/psum_acc_pkg.sv
// Shared defaults and width-generic helpers for the partial-sum accumulator.
package psum_acc_pkg;

    localparam int DEF_COLUMN = 6;
    localparam int DEF_OW     = 21;
    localparam int DEF_AW     = 32;
    localparam int DEF_QW     = 8;
    localparam int DEF_SW     = 5;

    localparam logic signed [DEF_QW-1:0] QMAX = {1'b0, {(DEF_QW-1){1'b1}}};
    localparam logic signed [DEF_QW-1:0] QMIN = {1'b1, {(DEF_QW-1){1'b0}}};

    // Sign-extend the low w bits of x to 64 bits; callers truncate to their width.
    function automatic logic [63:0] sext(input logic [63:0] x, input int w);
        logic [63:0] y;
        y = x;
        for (int i = 0; i < 64; i++) begin
            if (i >= w) y[i] = x[w-1];
        end
        return y;
    endfunction

    // Clamp r to the signed range of a qw-bit value.
    function automatic logic signed [63:0] sat(input logic signed [63:0] r, input int qw);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (qw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (qw - 1));
        if (r > hi)      return hi;
        else if (r < lo) return lo;
        else             return r;
    endfunction

endpackage

// File: rtl/psum_requant.sv
// Single-lane requantizer: round half toward +inf, arithmetic shift, saturate, optional ReLU.
module psum_requant
    import psum_acc_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int QW = DEF_QW,
    parameter int SW = DEF_SW
) (
    input  logic signed [AW-1:0] acc_i,
    input  logic        [SW-1:0] shift_i,
    input  logic                 relu_en_i,
    output logic signed [QW-1:0] q_o
);

    logic signed [AW:0] ext;
    logic signed [AW:0] rnd;
    logic signed [AW:0] sum;
    logic signed [AW:0] r;

    always_comb begin
        // One guard bit keeps the rounding add from wrapping near the top of the range.
        ext = {acc_i[AW-1], acc_i};
        rnd = '0;
        if (shift_i != '0) rnd = (AW+1)'(1) << (shift_i - SW'(1));
        sum = ext + rnd;
        r   = sum >>> shift_i;
        q_o = QW'(sat(64'(r), QW));
        if (relu_en_i && r[AW]) q_o = '0;
    end

endmodule

// File: rtl/psum_acc.sv
// Accumulates framed MAC-array partial sums per group, adds bias, and emits requantized activations.
module psum_acc
    import psum_acc_pkg::*;
#(
    parameter int COLUMN = DEF_COLUMN,
    parameter int OW     = DEF_OW,
    parameter int AW     = DEF_AW,
    parameter int QW     = DEF_QW,
    parameter int SW     = DEF_SW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [COLUMN*OW-1:0] acc_m_data,
    input  logic                 acc_m_first,
    input  logic                 acc_m_last,
    input  logic                 acc_m_valid,
    output logic                 acc_m_ready,
    input  logic [COLUMN*AW-1:0] bias,
    input  logic [SW-1:0]        shift,
    input  logic                 relu_en,
    output logic [COLUMN*QW-1:0] acc_s_data,
    output logic                 acc_s_valid,
    input  logic                 acc_s_ready,
    output logic                 acc_err
);

    logic [COLUMN-1:0][AW-1:0] acc_q, acc_d;
    logic [COLUMN-1:0][QW-1:0] q_lane;
    logic [COLUMN*QW-1:0]      data_q, data_d;
    logic [SW-1:0]             shift_q, shift_d;
    logic                      relu_q, relu_d;
    logic                      open_q, open_d;
    logic                      done_q, done_d;
    logic                      err_q, err_d;
    logic                      vld_q, vld_d;
    logic                      accept, load, start;

    assign load        = done_q && (!vld_q || acc_s_ready);
    assign acc_m_ready = !done_q || load;
    assign accept      = acc_m_valid && acc_m_ready;
    // A beat outside an open group always starts one, even if first is missing.
    assign start       = acc_m_first || !open_q;

    always_comb begin
        acc_d   = acc_q;
        shift_d = shift_q;
        relu_d  = relu_q;
        open_d  = open_q;
        done_d  = done_q;
        err_d   = err_q;
        vld_d   = vld_q;
        data_d  = data_q;

        if (accept) begin
            for (int k = 0; k < COLUMN; k++) begin
                acc_d[k] = (start ? bias[k*AW +: AW] : acc_q[k])
                         + AW'(sext(64'(acc_m_data[k*OW +: OW]), OW));
            end
            if (start) begin
                shift_d = shift;
                relu_d  = relu_en;
            end
            open_d = !acc_m_last;
            // first must be set exactly when no group is open.
            if (acc_m_first == open_q) err_d = 1'b1;
        end

        if (accept && acc_m_last) done_d = 1'b1;
        else if (load)            done_d = 1'b0;

        if (load) begin
            vld_d  = 1'b1;
            data_d = q_lane;
        end else if (acc_s_ready) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= '0;
            shift_q <= '0;
            relu_q  <= 1'b0;
            open_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            vld_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            acc_q   <= acc_d;
            shift_q <= shift_d;
            relu_q  <= relu_d;
            open_q  <= open_d;
            done_q  <= done_d;
            err_q   <= err_d;
            vld_q   <= vld_d;
            data_q  <= data_d;
        end
    end

    for (genvar k = 0; k < COLUMN; k++) begin : g_lane
        psum_requant #(.AW(AW), .QW(QW), .SW(SW)) u_rq (
            .acc_i     (acc_q[k]),
            .shift_i   (shift_q),
            .relu_en_i (relu_q),
            .q_o       (q_lane[k])
        );
    end

    assign acc_s_data  = data_q;
    assign acc_s_valid = vld_q;
    assign acc_err     = err_q;

endmodule

// File: tb/tb_psum_acc.sv
// Directed bench for psum_acc: reset, accumulate/requant, saturation, backpressure, framing.
module tb_psum_acc;

    localparam int COLUMN = 6;
    localparam int OW     = 21;
    localparam int AW     = 32;
    localparam int QW     = 8;
    localparam int SW     = 5;

    logic                 clk;
    logic                 rst;
    logic [COLUMN*OW-1:0] acc_m_data;
    logic                 acc_m_first;
    logic                 acc_m_last;
    logic                 acc_m_valid;
    logic                 acc_m_ready;
    logic [COLUMN*AW-1:0] bias;
    logic [SW-1:0]        shift;
    logic                 relu_en;
    logic [COLUMN*QW-1:0] acc_s_data;
    logic                 acc_s_valid;
    logic                 acc_s_ready;
    logic                 acc_err;

    int dv[COLUMN];
    int bv[COLUMN];
    int ev[COLUMN];
    int n_cmp;
    int n_err;

    psum_acc #(.COLUMN(COLUMN), .OW(OW), .AW(AW), .QW(QW), .SW(SW)) dut (
        .clk         (clk),
        .rst         (rst),
        .acc_m_data  (acc_m_data),
        .acc_m_first (acc_m_first),
        .acc_m_last  (acc_m_last),
        .acc_m_valid (acc_m_valid),
        .acc_m_ready (acc_m_ready),
        .bias        (bias),
        .shift       (shift),
        .relu_en     (relu_en),
        .acc_s_data  (acc_s_data),
        .acc_s_valid (acc_s_valid),
        .acc_s_ready (acc_s_ready),
        .acc_err     (acc_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        acc_m_data = '0;
        bias       = '0;
        for (int k = 0; k < COLUMN; k++) begin
            acc_m_data[k*OW +: OW] = OW'(dv[k]);
            bias[k*AW +: AW]       = AW'(bv[k]);
        end
    end

    function automatic logic [COLUMN*QW-1:0] expq();
        logic [COLUMN*QW-1:0] p;
        p = '0;
        for (int k = 0; k < COLUMN; k++) p[k*QW +: QW] = QW'(ev[k]);
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic f, input logic l);
        acc_m_first = f;
        acc_m_last  = l;
        acc_m_valid = 1'b1;
        tick();
        acc_m_valid = 1'b0;
        acc_m_first = 1'b0;
        acc_m_last  = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        acc_m_first = 1'b0;
        acc_m_last  = 1'b0;
        acc_m_valid = 1'b0;
        acc_s_ready = 1'b1;
        shift   = '0;
        relu_en = 1'b0;
        for (int k = 0; k < COLUMN; k++) begin dv[k] = 0; bv[k] = 0; ev[k] = 0; end

        // Reset
        tick();
        tick();
        chk("rst_valid", acc_s_valid, 0);
        chk("rst_data", acc_s_data, 0);
        chk("rst_ready", acc_m_ready, 1);
        chk("rst_err", acc_err, 0);
        rst = 1'b0;

        // Single-beat group: bias 10+k, data 20 -> 30+k, two-cycle latency
        for (int k = 0; k < COLUMN; k++) begin bv[k] = 10 + k; dv[k] = 20; ev[k] = 30 + k; end
        beat(1, 1);
        chk("lat_early", acc_s_valid, 0);
        tick();
        chk("single_valid", acc_s_valid, 1);
        chk("single_data", acc_s_data, expq());
        tick();
        chk("single_drain", acc_s_valid, 0);

        // Three-beat group, shift 2: 250+4k -> 63+k
        shift = 5'd2;
        for (int k = 0; k < COLUMN; k++) begin bv[k] = 0; dv[k] = 100 + 4*k; ev[k] = 63 + k; end
        beat(1, 0);
        for (int k = 0; k < COLUMN; k++) dv[k] = 200;
        beat(0, 0);
        for (int k = 0; k < COLUMN; k++) dv[k] = -50;
        beat(0, 1);
        tick();
        chk("multi_data", acc_s_data, expq());

        // Negative rounding, shift 1: -5-2k -> -2-k
        shift = 5'd1;
        for (int k = 0; k < COLUMN; k++) begin dv[k] = -5 - 2*k; ev[k] = -2 - k; end
        beat(1, 1);
        tick();
        chk("round_neg", acc_s_data, expq());

        // Saturation at and beyond the output range
        shift = 5'd0;
        dv = '{1000, -1000, 5, -5, 128, -129};
        ev = '{127, -128, 5, -5, 127, -128};
        beat(1, 1);
        tick();
        chk("sat_data", acc_s_data, expq());
        relu_en = 1'b1;
        ev = '{127, 0, 5, 0, 127, 0};
        beat(1, 1);
        tick();
        chk("relu_data", acc_s_data, expq());
        relu_en = 1'b0;
        tick();

        // Backpressure: output full, second group done
        acc_s_ready = 1'b0;
        for (int k = 0; k < COLUMN; k++) dv[k] = 1 + k;
        beat(1, 1);
        for (int k = 0; k < COLUMN; k++) dv[k] = 40 + k;
        beat(1, 1);
        for (int k = 0; k < COLUMN; k++) ev[k] = 1 + k;
        chk("bp_ready", acc_m_ready, 0);
        chk("bp_valid", acc_s_valid, 1);
        chk("bp_data_a", acc_s_data, expq());
        tick();
        chk("bp_hold_data", acc_s_data, expq());
        chk("bp_hold_ready", acc_m_ready, 0);
        acc_s_ready = 1'b1;
        tick();
        for (int k = 0; k < COLUMN; k++) ev[k] = 40 + k;
        chk("bp_data_b", acc_s_data, expq());
        chk("bp_valid_b", acc_s_valid, 1);
        chk("bp_ready_back", acc_m_ready, 1);
        tick();
        chk("bp_drain", acc_s_valid, 0);
        tick();
        chk("bp_no_dup", acc_s_valid, 0);

        // Framing: missing first after reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < COLUMN; k++) begin bv[k] = 7; dv[k] = 3 + k; ev[k] = 10 + k; end
        beat(0, 1);
        chk("frm_nofirst_err", acc_err, 1);
        tick();
        chk("frm_nofirst_data", acc_s_data, expq());

        // Framing: first while a group is open restarts it
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("frm_rst_err", acc_err, 0);
        for (int k = 0; k < COLUMN; k++) begin bv[k] = 0; dv[k] = 50; end
        beat(1, 0);
        chk("frm_ok_err", acc_err, 0);
        for (int k = 0; k < COLUMN; k++) begin dv[k] = 4 + k; ev[k] = 4 + k; end
        beat(1, 1);
        chk("frm_restart_err", acc_err, 1);
        tick();
        chk("frm_restart_data", acc_s_data, expq());
        tick();

        // Reset mid-group and with a pending result
        for (int k = 0; k < COLUMN; k++) dv[k] = 9;
        beat(1, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_err", acc_err, 0);
        chk("midrst_valid", acc_s_valid, 0);
        beat(1, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("pendrst_valid", acc_s_valid, 0);
        for (int k = 0; k < COLUMN; k++) begin dv[k] = 2 + k; ev[k] = 2 + k; end
        beat(0, 1);
        chk("rst_clears_open", acc_err, 1);
        tick();
        chk("post_rst_data", acc_s_data, expq());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
